// File: rtl/prog_pkg.sv
// +----------------------------------------------------------------------------+
// | prog_pkg: shared mode encoding, display constants and digit-code helper.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package prog_pkg;

  localparam logic [1:0] MODE_EDIT = 2'd0;
  localparam logic [1:0] MODE_RUN  = 2'd1;
  localparam logic [1:0] MODE_HALT = 2'd2;

  localparam logic [5:0] SEG_BLANK = 6'd10;

  // Byte lanes of a program word, most significant first
  localparam logic [1:0] LANE_OP = 2'd0;
  localparam logic [1:0] LANE_D1 = 2'd1;
  localparam logic [1:0] LANE_D2 = 2'd2;
  localparam logic [1:0] LANE_D3 = 2'd3;

  // Code 10 is reserved for blank, so hex digits A-F shift up by one
  function automatic logic [5:0] nib_code(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return {2'b00, nib};
    end
    return {2'b00, nib} + 6'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/prog_sequencer_btn_cond.sv
// +----------------------------------------------------------------------------+
// | btn_cond: raw button synchronizer, optional debounce, rising-edge pulse.    |
// | Optional feature macro: PROG_SEQ_DEBOUNCE_EN. Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module btn_cond #(
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= raw_i;
      s2_q <= s1_q;
    end
  end

`ifdef PROG_SEQ_DEBOUNCE_EN
  logic [19:0] cnt_q;
  logic        deb_q;

  // The debounced level follows the input only after a full stable window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      prev_q <= deb_q;
      if (s2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q >= DEB_CYCLES - 20'd1) begin
        deb_q <= s2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 20'd1;
      end
    end
  end

  assign pulse_o = deb_q & ~prev_q;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= s2_q;
    end
  end

  assign pulse_o = s2_q & ~prev_q;
`endif

endmodule

`default_nettype wire

// File: rtl/prog_sequencer.sv
// +----------------------------------------------------------------------------+
// | prog_sequencer: program buffer editor and run-mode streamer to executor.    |
// | Optional feature macro: PROG_SEQ_DEBOUNCE_EN. Revision: 1.0               |
// +----------------------------------------------------------------------------+
`default_nettype none

module prog_sequencer
  import prog_pkg::*;
#(
  parameter int          DEPTH      = 16,
  parameter int          AW         = 4,
  parameter logic [7:0]  HALT_OP    = 8'hFF,
  parameter logic [19:0] DEB_CYCLES = 20'd500000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_confirm,
  input  logic          btn_next,
  input  logic          btn_addr_inc,
  input  logic          btn_addr_dec,
  input  logic          btn_mode,
  input  logic [7:0]    edit_byte,
  output logic [31:0]   cur_word,
  output logic [1:0]    part,
  output logic [AW-1:0] addr,
  output logic [1:0]    mode,
  output logic [31:0]   exec_word,
  output logic          exec_valid,
  input  logic          exec_ready,
  output logic [AW-1:0] pc,
  output logic [5:0]    Seg1,
  output logic [5:0]    Seg2
);

  logic [4:0] w_raw, w_pulse;
  assign w_raw = {btn_mode, btn_addr_dec, btn_addr_inc, btn_next, btn_confirm};

  for (genvar gi = 0; gi < 5; gi++) begin : g_btn
    btn_cond #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
      .clk    (clk),
      .rst    (rst),
      .raw_i  (w_raw[gi]),
      .pulse_o(w_pulse[gi])
    );
  end

  logic w_mode_p, w_conf_p, w_next_p, w_inc_p, w_dec_p;
  assign w_mode_p = w_pulse[4];
  assign w_conf_p = w_pulse[0] & ~w_mode_p;
  assign w_next_p = w_pulse[1] & ~w_mode_p & ~w_pulse[0];
  assign w_inc_p  = w_pulse[2] & ~w_mode_p & ~w_pulse[0] & ~w_pulse[1];
  assign w_dec_p  = w_pulse[3] & ~(|w_pulse[2:0]) & ~w_mode_p;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] addr_q, addr_d, pc_q, pc_d, w_pc_nxt;
  logic [1:0]    part_q, part_d, mode_q, mode_d;
  logic [31:0]   word_q, word_d, cur_q;
  logic          valid_q, valid_d, pend_q, pend_d, w_pend, w_we;
  logic [5:0]    seg1_q, seg2_q, w_seg1, w_seg2;
  logic [4:0]    w_lsb;

  assign w_pc_nxt = pc_q + 1'b1;
  assign w_pend   = pend_q | w_mode_p;
  assign w_lsb    = {~part_q, 3'b000};

  always_comb begin
    addr_d  = addr_q;
    part_d  = part_q;
    pc_d    = pc_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    word_d  = word_q;
    pend_d  = pend_q;
    w_we    = 1'b0;
    case (mode_q)
      MODE_EDIT: begin
        if (w_mode_p) begin
          mode_d  = MODE_RUN;
          pc_d    = '0;
          valid_d = 1'b1;
          word_d  = mem_q[0];
          pend_d  = 1'b0;
        end else if (w_conf_p) begin
          w_we = 1'b1;
          if (part_q == LANE_D3) begin
            part_d = LANE_OP;
            addr_d = addr_q + 1'b1;
          end else begin
            part_d = part_q + 2'd1;
          end
        end else if (w_next_p) begin
          part_d = part_q + 2'd1;
        end else if (w_inc_p) begin
          addr_d = addr_q + 1'b1;
          part_d = LANE_OP;
        end else if (w_dec_p) begin
          addr_d = addr_q - 1'b1;
          part_d = LANE_OP;
        end
      end
      MODE_RUN: begin
        pend_d = w_pend;
        // A pending mode request waits until no word is in flight
        if (!valid_q) begin
          if (w_pend) begin
            mode_d = MODE_EDIT;
            pend_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            word_d  = mem_q[pc_q];
          end
        end else if (exec_ready) begin
          if (w_pend) begin
            mode_d  = MODE_EDIT;
            valid_d = 1'b0;
            pend_d  = 1'b0;
          end else if (word_q[31:24] == HALT_OP || pc_q == AW'(DEPTH - 1)) begin
            mode_d  = MODE_HALT;
            valid_d = 1'b0;
          end else begin
            pc_d   = w_pc_nxt;
            word_d = mem_q[w_pc_nxt];
          end
        end
      end
      MODE_HALT: begin
        valid_d = 1'b0;
        pend_d  = 1'b0;
        if (w_mode_p) begin
          mode_d = MODE_EDIT;
        end
      end
      default: begin
        mode_d  = MODE_EDIT;
        valid_d = 1'b0;
        pend_d  = 1'b0;
      end
    endcase
  end

  if (AW <= 4) begin : g_seg1_blank
    assign w_seg1 = SEG_BLANK;
  end else begin : g_seg1_hex
    assign w_seg1 = nib_code(4'(addr_d >> 4));
  end
  assign w_seg2 = nib_code(4'(addr_d));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      addr_q  <= '0;
      part_q  <= LANE_OP;
      pc_q    <= '0;
      mode_q  <= MODE_EDIT;
      valid_q <= 1'b0;
      word_q  <= '0;
      pend_q  <= 1'b0;
      cur_q   <= '0;
      seg1_q  <= SEG_BLANK;
      seg2_q  <= SEG_BLANK;
    end else begin
      if (w_we) begin
        mem_q[addr_q][w_lsb +: 8] <= edit_byte;
      end
      addr_q  <= addr_d;
      part_q  <= part_d;
      pc_q    <= pc_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      cur_q   <= mem_q[addr_q];
      seg1_q  <= w_seg1;
      seg2_q  <= w_seg2;
    end
  end

  assign cur_word   = cur_q;
  assign part       = part_q;
  assign addr       = addr_q;
  assign mode       = mode_q;
  assign exec_word  = word_q;
  assign exec_valid = valid_q;
  assign pc         = pc_q;
  assign Seg1       = seg1_q;
  assign Seg2       = seg2_q;

endmodule

`default_nettype wire

// File: tb/tb_prog_sequencer.sv
// +----------------------------------------------------------------------------+
// | tb_prog_sequencer: vector table for editing plus run-mode scoreboard.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_prog_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_confirm = 1'b0, btn_next = 1'b0, btn_addr_inc = 1'b0;
  logic        btn_addr_dec = 1'b0, btn_mode = 1'b0;
  logic [7:0]  edit_byte = 8'h00;
  logic        exec_ready = 1'b0;
  logic [31:0] cur_word, exec_word;
  logic [1:0]  part, mode;
  logic [3:0]  addr, pc;
  logic        exec_valid;
  logic [5:0]  Seg1, Seg2;

  prog_sequencer u_dut (
    .clk         (clk),
    .rst         (rst),
    .btn_confirm (btn_confirm),
    .btn_next    (btn_next),
    .btn_addr_inc(btn_addr_inc),
    .btn_addr_dec(btn_addr_dec),
    .btn_mode    (btn_mode),
    .edit_byte   (edit_byte),
    .cur_word    (cur_word),
    .part        (part),
    .addr        (addr),
    .mode        (mode),
    .exec_word   (exec_word),
    .exec_valid  (exec_valid),
    .exec_ready  (exec_ready),
    .pc          (pc),
    .Seg1        (Seg1),
    .Seg2        (Seg2)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // Handshakes are sampled mid-cycle, ahead of the edge that completes them
  always @(negedge clk) begin
    if (!rst && exec_valid && exec_ready) begin
      if (sb_q.size() == 0) begin
        vec_cnt++;
        err_cnt++;
        $display("FAIL sb_unexpected: got %h, required no handshake", exec_word);
      end else begin
        check("sb_exec_word", exec_word, sb_q.pop_front());
      end
    end
  end

  // mask bits: 0 confirm, 1 next, 2 addr_inc, 3 addr_dec, 4 mode
  task automatic press(input logic [4:0] mask, input logic [7:0] b);
    @(posedge clk);
    #2;
    edit_byte    = b;
    btn_confirm  = mask[0];
    btn_next     = mask[1];
    btn_addr_inc = mask[2];
    btn_addr_dec = mask[3];
    btn_mode     = mask[4];
    repeat (4) @(posedge clk);
    #2;
    {btn_mode, btn_addr_dec, btn_addr_inc, btn_next, btn_confirm} = 5'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0]  btns;
    logic [7:0]  b;
    logic [3:0]  exp_addr;
    logic [1:0]  exp_part;
    logic [31:0] exp_cur;
    logic [5:0]  exp_seg2;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0]  = '{5'b00001, 8'h12, 4'd0,  2'd1, 32'h12000000, 6'd0};
    tbl[1]  = '{5'b00001, 8'h34, 4'd0,  2'd2, 32'h12340000, 6'd0};
    tbl[2]  = '{5'b00001, 8'h56, 4'd0,  2'd3, 32'h12345600, 6'd0};
    tbl[3]  = '{5'b00001, 8'h78, 4'd1,  2'd0, 32'h00000000, 6'd1};
    tbl[4]  = '{5'b01000, 8'h00, 4'd0,  2'd0, 32'h12345678, 6'd0};
    tbl[5]  = '{5'b01000, 8'h00, 4'd15, 2'd0, 32'h00000000, 6'd16};
    tbl[6]  = '{5'b00010, 8'h00, 4'd15, 2'd1, 32'h00000000, 6'd16};
    tbl[7]  = '{5'b00011, 8'hAB, 4'd15, 2'd2, 32'h00AB0000, 6'd16};
    tbl[8]  = '{5'b00010, 8'h00, 4'd15, 2'd3, 32'h00AB0000, 6'd16};
    tbl[9]  = '{5'b00010, 8'h00, 4'd15, 2'd0, 32'h00AB0000, 6'd16};
    tbl[10] = '{5'b00100, 8'h00, 4'd0,  2'd0, 32'h12345678, 6'd0};
    tbl[11] = '{5'b01100, 8'h00, 4'd1,  2'd0, 32'h00000000, 6'd1};
    tbl[12] = '{5'b00010, 8'h00, 4'd1,  2'd1, 32'h00000000, 6'd1};
    tbl[13] = '{5'b00100, 8'h00, 4'd2,  2'd0, 32'h00000000, 6'd2};
    tbl[14] = '{5'b01111, 8'hCD, 4'd2,  2'd1, 32'hCD000000, 6'd2};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cur_word", cur_word, 32'h0);
    check("rst_exec_valid", {31'b0, exec_valid}, 32'h0);
    check("rst_mode", {30'b0, mode}, 32'h0);
    check("rst_seg1", {26'b0, Seg1}, 32'd10);
    check("rst_seg2", {26'b0, Seg2}, 32'd10);
    check("rst_addr_part_pc", {24'b0, addr, part, 2'b0} | {28'b0, pc}, 32'h0);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 15; i++) begin
      press(tbl[i].btns, tbl[i].b);
      check($sformatf("v%0d_addr", i), {28'b0, addr}, {28'b0, tbl[i].exp_addr});
      check($sformatf("v%0d_part", i), {30'b0, part}, {30'b0, tbl[i].exp_part});
      check($sformatf("v%0d_cur", i), cur_word, tbl[i].exp_cur);
      check($sformatf("v%0d_seg2", i), {26'b0, Seg2}, {26'b0, tbl[i].exp_seg2});
      check($sformatf("v%0d_seg1", i), {26'b0, Seg1}, 32'd10);
      check($sformatf("v%0d_mode", i), {30'b0, mode}, 32'h0);
    end

    // Two-word program ending on the halt opcode
    do_reset();
    begin
      logic [7:0] prog [8];
      prog = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
      for (int i = 0; i < 8; i++) press(5'b00001, prog[i]);
    end
    check("load_addr", {28'b0, addr}, 32'd2);
    exec_ready = 1'b1;
    sb_q.push_back(32'h01000000);
    sb_q.push_back(32'hFF000000);
    press(5'b10000, 8'h00);
    check("run1_mode_halt", {30'b0, mode}, 32'd2);
    check("run1_pc", {28'b0, pc}, 32'd1);
    check("run1_valid", {31'b0, exec_valid}, 32'h0);
    check("run1_sb_drained", sb_q.size(), 32'd0);
    @(posedge clk);
    #2 exec_ready = 1'b0;

    press(5'b10000, 8'h00);
    check("halt_to_edit", {30'b0, mode}, 32'd0);
    check("edit_kept_addr", {28'b0, addr}, 32'd2);

    // Stalled executor with a deferred mode request
    press(5'b10000, 8'h00);
    check("run2_mode", {30'b0, mode}, 32'd1);
    check("run2_pc", {28'b0, pc}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", i), {31'b0, exec_valid}, 32'd1);
      check($sformatf("stall%0d_word", i), exec_word, 32'h01000000);
    end
    press(5'b10000, 8'h00);
    check("pend_mode_run", {30'b0, mode}, 32'd1);
    check("pend_valid", {31'b0, exec_valid}, 32'd1);
    check("pend_word", exec_word, 32'h01000000);
    sb_q.push_back(32'h01000000);
    @(posedge clk);
    #2 exec_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pend_exit_mode", {30'b0, mode}, 32'd0);
    check("pend_exit_valid", {31'b0, exec_valid}, 32'd0);
    check("run2_sb_drained", sb_q.size(), 32'd0);
    @(posedge clk);
    #2 exec_ready = 1'b0;

    // Reset while a word is on offer
    press(5'b10000, 8'h00);
    check("run3_valid", {31'b0, exec_valid}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {31'b0, exec_valid}, 32'd0);
    check("midrst_mode", {30'b0, mode}, 32'd0);
    check("midrst_seg1", {26'b0, Seg1}, 32'd10);
    check("midrst_seg2", {26'b0, Seg2}, 32'd10);
    check("midrst_addr", {28'b0, addr}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("midrst_mem0", cur_word, 32'h0);
    press(5'b00100, 8'h00);
    check("midrst_mem1", cur_word, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Controller for the programmable-instruction datapath. It owns a DEPTH-entry program buffer of 32-bit words (op, d1, d2, d3 bytes) and sequences byte-wise editing from board buttons and switches. In run mode it streams the stored program to the executor over a valid/ready handshake. It sits between the board I/O (buttons, switch byte, seven-segment digits 1-2) and the executor. It replaces button-clocked logic with single-clock edge-detected control.

Parameters:
DEPTH, 16, number of program words; must be a power of two, 2 to 256.
AW, 4, address width; equals log2(DEPTH).
HALT_OP, 8'hFF, opcode byte that ends a run.
DEB_CYCLES, 20'd500000, debounce stability window in clk cycles; used only with the optional feature.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
btn_confirm  in  1  raw button: write byte
btn_next  in  1  raw button: advance part
btn_addr_inc  in  1  raw button: address +1
btn_addr_dec  in  1  raw button: address -1
btn_mode  in  1  raw button: mode toggle
edit_byte  in  8  byte to write (switch-assembled)
cur_word  out  32  registered mem[addr], to editor display
part  out  2  selected byte: 0 = [31:24] ... 3 = [7:0]
addr  out  AW  edit address
mode  out  2  0 = EDIT, 1 = RUN, 2 = HALT
exec_word  out  32  word offered to executor
exec_valid  out  1  exec_word valid
exec_ready  in  1  executor accepts
pc  out  AW  run pointer
Seg1  out  6  addr high nibble digit code
Seg2  out  6  addr low nibble digit code

Behaviour:
- Reset (async, active-high): all mem words 0; addr=0, part=0, pc=0, mode=EDIT, exec_valid=0, exec_word=0, cur_word=0; Seg1=Seg2=10 (blank).
- Buttons: 2-flop synchronizer, then rising-edge detect gives a one-cycle pulse. Action latency is 3 cycles from the raw edge to the register update.
- Pulse priority, one action per cycle: mode > confirm > next > addr_inc > addr_dec. Lower-priority pulses in the same cycle are discarded.
- EDIT state:
  - confirm: write edit_byte into the mem[addr] byte selected by part.
  - If part<3 after confirm, part+1. If part==3, part=0 and addr+1, wrapping DEPTH-1 to 0.
  - next: part+1, wrapping 3 to 0.
  - addr_inc / addr_dec: addr±1 with wrap; part forced to 0.
  - mode: go to RUN with pc=0.
- cur_word: mem[addr] registered; reflects a write or address change one cycle later.
- RUN state:
  - exec_valid=1 with exec_word=mem[pc].
  - Once exec_valid is asserted, exec_word holds stable until exec_ready is sampled high.
  - On handshake: if exec_word[31:24]==HALT_OP go to HALT. Else if pc==DEPTH-1 go to HALT. Else pc+1 and present the next word on the following cycle (one cycle per word when ready is held high).
  - confirm, next, addr_inc and addr_dec are ignored in RUN.
  - mode pulse is deferred: a pending flag is set, and the state returns to EDIT on the next cycle where exec_valid=0 or a handshake completes. The word in flight is never withdrawn.
- HALT state: exec_valid=0; pc holds the last issued index; mode goes to EDIT; other buttons ignored.
- Edit state (addr, part, mem) is preserved across RUN/HALT.
- Seg digit code: nibble<10 gives the nibble; otherwise nibble+1 (codes 11-16, since 10 is blank). With AW<=4, Seg1=10 (blank).
- Reset asserted mid-run: exec_valid drops immediately.

Optional Feature:
PROG_SEQ_DEBOUNCE_EN
- Defined: each synchronized button feeds a counter. The debounced level changes only after the input has been stable for DEB_CYCLES cycles, and edge detect runs on the debounced level. Latency becomes DEB_CYCLES+3.
- Undefined: synchronizer plus edge detect only; DEB_CYCLES is unused.

Decomposition:
- Shared package prog_pkg: mode encoding (MODE_EDIT, MODE_RUN, MODE_HALT), SEG_BLANK=10, byte-lane constants, and a nibble-to-digit-code function reusable by the editor display logic.
- One sub-module, btn_cond: synchronizer, optional debounce, and edge detect. It is instantiated once per button.

Test Plan:
- Reset, then confirm with edit_byte=8'h12, 8'h34, 8'h56, 8'h78 -> mem[0]=32'h12345678, addr=1, part=0, cur_word=0.
- addr_dec from addr=0 -> addr=DEPTH-1=15, Seg1=10, Seg2=16; cur_word=mem[15].
- Load mem[0]=32'h01000000, mem[1]=32'hFF000000, press mode, exec_ready=1 -> two handshakes (exec_word 32'h01000000 then 32'hFF000000), then mode=HALT, pc=1, exec_valid=0.
- RUN with exec_ready=0 for 5 cycles, mode pressed -> exec_valid and exec_word held stable. Raise ready -> one handshake, then mode=EDIT on the next cycle.
- confirm and next pulses in the same cycle in EDIT -> only the byte write occurs; part advances once (0 to 1).
- rst asserted mid-RUN while exec_valid=1 -> exec_valid=0, mem cleared, mode=EDIT, Seg1=Seg2=10.
